// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment encode/decode path.
// Segment patterns are 7 bits ordered {g,f,e,d,c,b,a} and active-high.
// Contents: pattern constants SEG_0..SEG_9 and SEG_BLANK, the scan
// tracker state type, and a helper that maps a digit to its pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Encoder-side mapping; digits above 9 give a blank display.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
// Combinational inverse of the seven-segment encoder.
// Ports:
//   i_seg   [6:0]  segment pattern {g,f,e,d,c,b,a}
//   o_bcd   [3:0]  decoded digit, 0 when the pattern is illegal
//   o_legal        pattern is one of the ten digit codes
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_legal
);

  always_comb begin
    o_bcd   = 4'd0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:   o_bcd = 4'd0;
      SEG_1:   o_bcd = 4'd1;
      SEG_2:   o_bcd = 4'd2;
      SEG_3:   o_bcd = 4'd3;
      SEG_4:   o_bcd = 4'd4;
      SEG_5:   o_bcd = 4'd5;
      SEG_6:   o_bcd = 4'd6;
      SEG_7:   o_bcd = 4'd7;
      SEG_8:   o_bcd = 4'd8;
      SEG_9:   o_bcd = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Watches a multiplexed seven-segment bus and rebuilds the displayed digits
// as BCD. A digit is committed once its (select, pattern) pair has been seen
// unchanged on STABLE_CNT consecutive clock edges.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | select not one-hot; nothing is being tracked
// TRACK | one-hot select, counting identical samples toward a commit
// HOLD  | current pair already committed; wait for it to change
//
// Ports:
//   i_clock            system clock, rising edge
//   i_reset            synchronous active-high reset
//   i_seg_in  [7:0]    segment bus, [6:0] = g..a, bit 7 ignored
//   i_dig_sel [NDIG]   one-hot digit select
//   o_bcd_out [4*NDIG] decoded digits, digit k at [4k+3:4k]
//   o_valid   [NDIG]   digit k holds a committed legal pattern
//   o_err     [NDIG]   last commit for digit k was illegal
//   o_upd              one-cycle pulse on every commit
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [7:0]          i_seg_in,
  input  logic [NDIG-1:0]     i_dig_sel,
  output logic [4*NDIG-1:0]   o_bcd_out,
  output logic [NDIG-1:0]     o_valid,
  output logic [NDIG-1:0]     o_err,
  output logic                o_upd
);

  localparam int              CW       = $clog2(STABLE_CNT) + 1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [NDIG-1:0]        r_prev_sel;
  logic [6:0]             r_prev_seg;
  logic [NDIG-1:0][3:0]   r_bcd;
  logic [NDIG-1:0]        r_valid;
  logic [NDIG-1:0]        r_err;
  logic                   r_upd;

  logic                   w_seen;
  logic                   w_multi;
  logic                   w_onehot;
  logic                   w_match;
  logic [3:0]             w_bcd;
  logic                   w_legal;
  logic                   w_unused_seg_bit7;

  // The decimal point carries no digit information.
  assign w_unused_seg_bit7 = i_seg_in[7];

  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (i_dig_sel[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
    w_onehot = w_seen & ~w_multi;
  end

  assign w_match = (i_dig_sel == r_prev_sel) && (i_seg_in[6:0] == r_prev_seg);

  // On a commit edge the inputs match the stored pair, so decoding the
  // registered pattern gives the same answer as decoding the live bus.
  seg7_pattern_decode u_decode (
    .i_seg   (r_prev_seg),
    .o_bcd   (w_bcd),
    .o_legal (w_legal)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_prev_sel <= '0;
      r_prev_seg <= '0;
      r_bcd      <= '0;
      r_valid    <= '0;
      r_err      <= '0;
      r_upd      <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (!w_onehot) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_prev_sel <= i_dig_sel;
        r_prev_seg <= i_seg_in[6:0];
      end else begin
        case (r_state)
          IDLE: begin
            r_state    <= TRACK;
            r_cnt      <= CNT_ONE;
            r_prev_sel <= i_dig_sel;
            r_prev_seg <= i_seg_in[6:0];
          end
          TRACK: begin
            if (!w_match) begin
              r_cnt      <= CNT_ONE;
              r_prev_sel <= i_dig_sel;
              r_prev_seg <= i_seg_in[6:0];
            end else if (r_cnt == CNT_LAST) begin
              r_state <= HOLD;
              r_upd   <= 1'b1;
              for (int k = 0; k < NDIG; k++) begin
                if (r_prev_sel[k]) begin
                  if (w_legal) begin
                    r_bcd[k]   <= w_bcd;
                    r_valid[k] <= 1'b1;
                    r_err[k]   <= 1'b0;
                  end else begin
                    r_valid[k] <= 1'b0;
                    r_err[k]   <= 1'b1;
                  end
                end
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          HOLD: begin
            if (!w_match) begin
              r_state    <= TRACK;
              r_cnt      <= CNT_ONE;
              r_prev_sel <= i_dig_sel;
              r_prev_seg <= i_seg_in[6:0];
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_bcd_out = r_bcd;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_upd     = r_upd;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  localparam int NDIG       = 4;
  localparam int STABLE_CNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic [15:0] bcd_out;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CNT(STABLE_CNT)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_seg_in  (seg),
    .i_dig_sel (sel),
    .o_bcd_out (bcd_out),
    .o_valid   (valid),
    .o_err     (err),
    .o_upd     (upd)
  );

  always #5 clk = ~clk;

  // Legal digit patterns, index = digit value.
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: length of the current run of identical one-hot samples.
  int         m_bcd [NDIG];
  logic [3:0] m_valid, m_err;
  logic       m_upd;
  int         m_run;
  logic       m_done;
  logic [3:0] m_last_sel;
  logic [6:0] m_last_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_bcd_vec();
    logic [15:0] v = '0;
    for (int k = 0; k < NDIG; k++) v[4*k +: 4] = m_bcd[k][3:0];
    return v;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] s, input logic [7:0] g);
    int k;
    int d;
    if (r) begin
      for (int i = 0; i < NDIG; i++) m_bcd[i] = 0;
      m_valid = '0; m_err = '0; m_upd = 0;
      m_run = 0; m_done = 0; m_last_sel = '0; m_last_seg = '0;
      return;
    end
    m_upd = 0;
    if ($countones(s) != 1) begin
      m_run = 0;
      m_done = 0;
    end else if (m_run > 0 && s == m_last_sel && g[6:0] == m_last_seg) begin
      m_run++;
    end else begin
      m_run = 1;
      m_done = 0;
    end
    m_last_sel = s;
    m_last_seg = g[6:0];
    if (m_run == STABLE_CNT && !m_done) begin
      m_done = 1;
      m_upd = 1;
      k = 0;
      for (int i = 0; i < NDIG; i++) if (s[i]) k = i;
      d = -1;
      for (int i = 0; i < 10; i++) if (pat[i] == g[6:0]) d = i;
      if (d >= 0) begin
        m_bcd[k] = d; m_valid[k] = 1; m_err[k] = 0;
      end else begin
        m_valid[k] = 0; m_err[k] = 1;
      end
    end
  endtask

  // One clock edge with the given inputs; DUT compared against the model.
  task automatic step(input logic r, input logic [3:0] s, input logic [7:0] g);
    rst = r; sel = s; seg = g;
    @(posedge clk);
    #1;
    model_step(r, s, g);
    check("model_bcd",   bcd_out, model_bcd_vec());
    check("model_valid", valid,   m_valid);
    check("model_err",   err,     m_err);
    check("model_upd",   upd,     m_upd);
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  sel;
    logic [7:0]  seg;
    int          n;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  err;
    int          upds;
  } vec_t;

  vec_t vt [18];

  initial begin
    int upds;
    int hold;
    logic [3:0] rs;
    logic [7:0] rg;
    logic       rr;

    rst = 1; sel = '0; seg = 8'hFF;
    model_step(1'b1, '0, '0);

    //          rst  sel    seg    n   bcd       valid  err    upds
    vt[0]  = '{1'b1, 4'h0, 8'hFF, 2,  16'h0000, 4'h0, 4'h0, 0};
    vt[1]  = '{1'b0, 4'h0, 8'hFF, 10, 16'h0000, 4'h0, 4'h0, 0};
    vt[2]  = '{1'b0, 4'h1, 8'hBF, 4,  16'h0000, 4'h1, 4'h0, 1};
    vt[3]  = '{1'b0, 4'h1, 8'hBF, 4,  16'h0000, 4'h1, 4'h0, 0};
    vt[4]  = '{1'b0, 4'h2, 8'h86, 3,  16'h0000, 4'h1, 4'h0, 0};
    vt[5]  = '{1'b0, 4'h2, 8'h5B, 4,  16'h0020, 4'h3, 4'h0, 1};
    vt[6]  = '{1'b0, 4'h4, 8'h87, 4,  16'h0720, 4'h7, 4'h0, 1};
    vt[7]  = '{1'b0, 4'h4, 8'h80, 4,  16'h0720, 4'h3, 4'h4, 1};
    vt[8]  = '{1'b0, 4'h3, 8'h86, 6,  16'h0720, 4'h3, 4'h4, 0};
    vt[9]  = '{1'b0, 4'h8, 8'hE6, 3,  16'h0720, 4'h3, 4'h4, 0};
    vt[10] = '{1'b1, 4'h8, 8'hE6, 1,  16'h0000, 4'h0, 4'h0, 0};
    vt[11] = '{1'b0, 4'h1, 8'h06, 3,  16'h0000, 4'h0, 4'h0, 0};
    vt[12] = '{1'b0, 4'h1, 8'h07, 1,  16'h0000, 4'h0, 4'h0, 0};
    vt[13] = '{1'b0, 4'h1, 8'h06, 3,  16'h0000, 4'h0, 4'h0, 0};
    vt[14] = '{1'b0, 4'h1, 8'h06, 1,  16'h0001, 4'h1, 4'h0, 1};
    vt[15] = '{1'b0, 4'h1, 8'h86, 3,  16'h0001, 4'h1, 4'h0, 0};
    vt[16] = '{1'b0, 4'h0, 8'h06, 1,  16'h0001, 4'h1, 4'h0, 0};
    vt[17] = '{1'b0, 4'h1, 8'h06, 4,  16'h0001, 4'h1, 4'h0, 1};

    for (int i = 0; i < 18; i++) begin
      upds = 0;
      for (int e = 0; e < vt[i].n; e++) begin
        step(vt[i].rst, vt[i].sel, vt[i].seg);
        upds += int'(upd);
      end
      check($sformatf("vec%0d_bcd", i),   bcd_out,        vt[i].bcd);
      check($sformatf("vec%0d_valid", i), valid,          vt[i].valid);
      check($sformatf("vec%0d_err", i),   err,            vt[i].err);
      check($sformatf("vec%0d_upds", i),  32'(upds),      32'(vt[i].upds));
    end

    // Sweep all legal codes on digit 3 with the decimal point toggling.
    for (int d = 0; d < 10; d++) begin
      upds = 0;
      for (int e = 0; e < STABLE_CNT; e++) begin
        step(1'b0, 4'h8, {(d % 2 == 0), pat[d]});
        upds += int'(upd);
      end
      check($sformatf("sweep%0d_digit", d), bcd_out[15:12], d[3:0]);
      check($sformatf("sweep%0d_valid", d), valid[3],       1'b1);
      check($sformatf("sweep%0d_err", d),   err[3],         1'b0);
      check($sformatf("sweep%0d_upds", d),  32'(upds),      32'd1);
    end

    // Random bursts against the model.
    for (int b = 0; b < 700; b++) begin
      rr = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 9))
        0:       rs = 4'h0;
        1:       rs = 4'($urandom);
        default: rs = 4'(1 << $urandom_range(0, NDIG - 1));
      endcase
      if ($urandom_range(0, 9) < 7)
        rg = {1'($urandom), pat[$urandom_range(0, 9)]};
      else
        rg = 8'($urandom);
      hold = rr ? 1 : $urandom_range(1, 6);
      for (int e = 0; e < hold; e++) begin
        // Occasionally wiggle bit 7 only; it must not break the run.
        if (!rr && $urandom_range(0, 5) == 0) rg[7] = ~rg[7];
        step(rr, rs, rg);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-seven-segment encoder. Monitors a scanned, multiplexed 7-segment bus (segment lines plus one-hot digit select) and reconstructs the displayed digits as BCD.
- Each digit is committed only after its pattern is stable. Each digit carries valid and error flags.
- Used in the bike display path for readback/self-check of what the display is actually driven with.

Parameters:
- NDIG, 4: number of scanned digits (width of dig_sel); must be >= 1.
- STABLE_CNT, 4: consecutive identical samples required before commit; must be >= 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- seg_in  input  8  segment bus; bits 6:0 = g,f,e,d,c,b,a active-high; bit 7 ignored.
- dig_sel  input  NDIG  digit select, active-high, expected one-hot.
- bcd_out  output  4*NDIG  decoded digits; digit k at bits 4k+3:4k.
- valid  output  NDIG  digit k holds a committed legal pattern.
- err  output  NDIG  last commit for digit k was an illegal pattern.
- upd  output  1  one-cycle pulse on any commit.

Behaviour:
- Legal code table on seg_in[6:0]:
  - 7'h3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - Every other value is illegal.
- Reset, while reset=1 at an edge:
  - bcd_out=0, valid=0, err=0, upd=0.
  - Sample register cleared, cnt=0, state=IDLE.
  - Reset overrides any in-progress window; no commit occurs on a reset edge.
- Sample tracking:
  - The module keeps prev_sel/prev_seg (seg bits 6:0 only) and cnt, of width clog2(STABLE_CNT)+1.
  - An input pair "matches" when dig_sel==prev_sel and seg_in[6:0]==prev_seg.
- States:
  - IDLE: dig_sel not one-hot (zero or more than one bit set). cnt<=0, prev<=inputs, no commit. Any edge with a non-one-hot dig_sel moves to IDLE from any state.
  - TRACK: one-hot and counting.
    - Mismatch: prev<=inputs, cnt<=1.
    - Match with cnt<STABLE_CNT-1: cnt<=cnt+1.
    - Match with cnt==STABLE_CNT-1: commit on this edge, then go to HOLD.
  - HOLD: committed. Match: stay, with no further commit and cnt frozen. Mismatch with one-hot select: go to TRACK, cnt<=1, prev<=inputs.
  - From IDLE, a one-hot dig_sel goes to TRACK with cnt<=1, prev<=inputs.
- Latency: a pair held unchanged across STABLE_CNT consecutive rising edges commits on the STABLE_CNT-th edge. Outputs are visible immediately after that edge.
- Commit to digit k (index of the set bit in dig_sel):
  - Legal pattern: bcd_out[k]<=code, valid[k]<=1, err[k]<=0.
  - Illegal pattern: valid[k]<=0, err[k]<=1, bcd_out[k] retains its previous value.
  - In both cases upd<=1 for exactly that cycle; upd=0 on all other cycles.
  - Other digits are untouched.
- Bit 7 of seg_in plays no part in matching or decoding.
- A pattern change of a single cycle restarts the window. There is no partial credit.
- A re-commit of an identical value still pulses upd; this requires leaving and re-entering via mismatch.

Decomposition:
- Shared package seg7_pkg:
  - Constants SEG_0..SEG_9 (7-bit patterns, common to the encoder and this decoder).
  - Constant SEG_BLANK.
  - State typedef {IDLE, TRACK, HOLD}.
- Sub-module seg7_pattern_decode: purely combinational. Maps 7-bit pattern to 4-bit bcd plus legal flag. Instantiated once, on prev_seg.
- Top module contains the tracking FSM, counter, one-hot check and per-digit registers.

Test Plan:
All tests use NDIG=4, STABLE_CNT=4.
1. Reset held 2 edges, then dig_sel=0, seg=8'hFF for 10 edges -> bcd_out=16'h0000, valid=0, err=0, upd never 1.
2. dig_sel=0001, seg=8'hBF held 8 edges -> at edge 4 valid=0001, bcd_out[3:0]=0, upd=1 for one cycle only; no further upd on edges 5-8.
3. dig_sel=0010, seg=8'h86 for 3 edges, then 8'h5B for 4 edges -> no commit after the first 3; at edge 7 bcd_out[7:4]=2, valid[1]=1.
4. Commit 8'h87 on digit 2 (bcd_out[11:8]=7), then seg=8'h80 on digit 2 for 4 edges -> err[2]=1, valid[2]=0, bcd_out[11:8] stays 7, upd pulses.
5. dig_sel=0011 with seg=8'h86 for 6 edges -> no commit. Then dig_sel=1000 with 8'hE6 for 3 edges, reset on edge 4 -> all outputs 0, no upd.
6. Sweep all ten legal patterns on digit 3, each held 4 edges, alternating bit7=1/0 -> bcd_out[15:12] follows 0..9, valid[3]=1, err[3]=0, ten upd pulses.
